// File: rtl/iigs_speed_ctl_if.sv
// CPU bus view for iigs_speed_ctl: cycle address/qualifiers toward the scheduler,
// clock enable back to the CPU.
interface iigs_speed_ctl_if;
    logic [7:0]  bank;
    logic [15:0] addr;
    logic        valid;
    logic        cpu_we;
    logic        cpu_ce;

    modport master (output bank, addr, valid, cpu_we, input cpu_ce);
    modport slave  (input bank, addr, valid, cpu_we, output cpu_ce);
endinterface

// File: rtl/iigs_speed_ctl.sv
// IIgs CPU clock-enable scheduler: fast cycles, Mega II-synchronised slow cycles,
// and (with IIGS_SPEED_REFRESH_EN defined) periodic stolen DRAM refresh cycles.
module iigs_speed_ctl #(
    parameter int unsigned REFRESH_PERIOD = 9,
    parameter int unsigned STAT_W         = 16
) (
    input  logic                  clk_sys,
    input  logic                  reset_n,
    input  logic                  fast_tick,
    input  logic                  slow_tick,
    input  logic [7:0]            cyareg,
    input  logic [3:0]            motor_on,
    input  logic [7:0]            shadow,
    iigs_speed_ctl_if.slave       bus,
    output logic                  slow_cycle,
    output logic                  refresh_busy,
    output logic [STAT_W-1:0]     slow_count
);

    localparam logic [1:0] ST_FAST    = 2'd0;
    localparam logic [1:0] ST_SYNC    = 2'd1;
    localparam logic [1:0] ST_SLOW    = 2'd2;
    localparam logic [1:0] ST_REFRESH = 2'd3;

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic       slow_req;
    logic       refresh_due;
    logic       ce;
    logic       fast_ce;
    logic       slow_done;

    logic bank_sys;
    logic bank_mega;
    logic is_write;
    logic shadow_wr_slow;

    // Slow-cycle classification from speed register, motor detect and address map.
    always_comb begin
        bank_sys  = (bus.bank == 8'h00) || (bus.bank == 8'h01);
        bank_mega = (bus.bank == 8'hE0) || (bus.bank == 8'hE1);
        is_write  = bus.valid && !bus.cpu_we;

        shadow_wr_slow = 1'b0;
        if (is_write && bank_sys) begin
            if ((bus.addr[15:10] == 6'b000001) && !shadow[0])
                shadow_wr_slow = 1'b1;
            if ((bus.addr[15:13] == 3'b001) && !shadow[1])
                shadow_wr_slow = 1'b1;
            if ((bus.addr[15:13] == 3'b010) && !shadow[2])
                shadow_wr_slow = 1'b1;
            if ((bus.bank == 8'h01) && (bus.addr >= 16'h2000) && (bus.addr <= 16'h9FFF)
                && !shadow[3])
                shadow_wr_slow = 1'b1;
        end

        slow_req = !cyareg[7]
                || (|(cyareg[3:0] & motor_on))
                || (bus.valid && bank_mega)
                || (bus.valid && (bank_sys || bank_mega)
                    && (bus.addr[15:8] == 8'hC0) && !shadow[6])
                || shadow_wr_slow;
    end

`ifdef IIGS_SPEED_REFRESH_EN
    localparam logic [7:0] REF_LAST = 8'(REFRESH_PERIOD);
    logic [7:0] ref_cnt;

    assign refresh_due  = (ref_cnt == REF_LAST);
    assign refresh_busy = (state == ST_REFRESH);

    // Counts fast cpu_ce pulses since the last refresh or slow cycle.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n)
            ref_cnt <= '0;
        else if (slow_done || ((state == ST_REFRESH) && fast_tick))
            ref_cnt <= '0;
        else if (fast_ce)
            ref_cnt <= ref_cnt + 8'd1;
    end
`else
    assign refresh_due  = 1'b0;
    assign refresh_busy = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        ce        = 1'b0;
        fast_ce   = 1'b0;
        slow_done = 1'b0;
        case (state)
            ST_FAST: begin
                if (fast_tick) begin
                    if (refresh_due)
                        state_nxt = ST_REFRESH;
                    else if (slow_req)
                        state_nxt = slow_tick ? ST_SLOW : ST_SYNC;
                    else begin
                        ce      = 1'b1;
                        fast_ce = 1'b1;
                    end
                end
            end
            ST_SYNC: begin
                if (slow_tick)
                    state_nxt = ST_SLOW;
            end
            ST_SLOW: begin
                if (slow_tick) begin
                    ce        = 1'b1;
                    slow_done = 1'b1;
                    state_nxt = ST_FAST;
                end
            end
            ST_REFRESH: begin
                if (fast_tick)
                    state_nxt = ST_FAST;
            end
            default: state_nxt = ST_FAST;
        endcase
    end

    // Gated by reset_n so an abandoned cycle never leaks a clock enable.
    assign bus.cpu_ce = ce && reset_n;
    assign slow_cycle = (state == ST_SYNC) || (state == ST_SLOW);

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_FAST;
            slow_count <= '0;
        end else begin
            state <= state_nxt;
            if (slow_done)
                slow_count <= slow_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_iigs_speed_ctl.sv
// Self-checking bench for iigs_speed_ctl: directed test-plan scenarios plus
// randomized traffic compared every clock against a tick-counting reference model.
module tb_iigs_speed_ctl;

    localparam int unsigned PERIOD = 9;
    localparam int unsigned STAT_W = 4;
`ifdef IIGS_SPEED_REFRESH_EN
    localparam bit REF_ON = 1'b1;
`else
    localparam bit REF_ON = 1'b0;
`endif

    logic              clk_sys = 1'b0;
    logic              reset_n = 1'b1;
    logic              fast_tick = 1'b0;
    logic              slow_tick = 1'b0;
    logic [7:0]        cyareg;
    logic [3:0]        motor_on;
    logic [7:0]        shadow;
    logic              slow_cycle;
    logic              refresh_busy;
    logic [STAT_W-1:0] slow_count;

    iigs_speed_ctl_if bus();

    iigs_speed_ctl #(.REFRESH_PERIOD(PERIOD), .STAT_W(STAT_W)) dut (
        .clk_sys      (clk_sys),
        .reset_n      (reset_n),
        .fast_tick    (fast_tick),
        .slow_tick    (slow_tick),
        .cyareg       (cyareg),
        .motor_on     (motor_on),
        .shadow       (shadow),
        .bus          (bus.slave),
        .slow_cycle   (slow_cycle),
        .refresh_busy (refresh_busy),
        .slow_count   (slow_count)
    );

    always #5 clk_sys = ~clk_sys;

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference classification written directly from the address map rules.
    function automatic bit slow_class(input logic [7:0] cya, input logic [3:0] mot,
                                      input logic [7:0] sh, input logic [7:0] bk,
                                      input logic [15:0] a, input logic v, input logic we);
        int  ai   = int'(a);
        int  b    = int'(bk);
        bit  sysb = (b == 0) || (b == 1);
        bit  mega = (b == 'hE0) || (b == 'hE1);
        if (!cya[7]) return 1'b1;
        if ((cya[3:0] & mot) != 4'h0) return 1'b1;
        if (v && mega) return 1'b1;
        if (v && (sysb || mega) && ai >= 'hC000 && ai <= 'hC0FF && !sh[6]) return 1'b1;
        if (v && !we && sysb) begin
            if (ai >= 'h0400 && ai <= 'h07FF && !sh[0]) return 1'b1;
            if (ai >= 'h2000 && ai <= 'h3FFF && !sh[1]) return 1'b1;
            if (ai >= 'h4000 && ai <= 'h5FFF && !sh[2]) return 1'b1;
            if (b == 1 && ai >= 'h2000 && ai <= 'h9FFF && !sh[3]) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Model: slow_left = slow_ticks still needed before the slow cycle ends.
    int          slow_left = 0;
    bit          in_refresh = 1'b0;
    int          fast_run = 0;
    int unsigned done_cnt = 0;

    always @(negedge clk_sys) begin : model
        bit exp_ce;
        bit pre_sc;
        bit pre_rb;
        int pre_cnt;
        if (!reset_n) begin
            slow_left  = 0;
            in_refresh = 1'b0;
            fast_run   = 0;
            done_cnt   = 0;
        end
        exp_ce  = 1'b0;
        pre_sc  = (slow_left > 0);
        pre_rb  = in_refresh;
        pre_cnt = int'(done_cnt % (1 << STAT_W));
        if (reset_n) begin
            if (in_refresh) begin
                if (fast_tick) begin
                    in_refresh = 1'b0;
                    fast_run   = 0;
                end
            end else if (slow_left > 0) begin
                if (slow_tick) begin
                    slow_left--;
                    if (slow_left == 0) begin
                        exp_ce   = 1'b1;
                        done_cnt++;
                        fast_run = 0;
                    end
                end
            end else if (fast_tick) begin
                if (REF_ON && fast_run >= int'(PERIOD))
                    in_refresh = 1'b1;
                else if (slow_class(cyareg, motor_on, shadow, bus.bank, bus.addr,
                                    bus.valid, bus.cpu_we))
                    slow_left = slow_tick ? 1 : 2;
                else begin
                    exp_ce = 1'b1;
                    fast_run++;
                end
            end
        end
        chk("cpu_ce", 32'(bus.cpu_ce), 32'(exp_ce));
        chk("slow_cycle", 32'(slow_cycle), 32'(pre_sc));
        chk("refresh_busy", 32'(refresh_busy), 32'(pre_rb));
        chk("slow_count", 32'(slow_count), 32'(pre_cnt));
    end

    logic              obs_ce, obs_sc, obs_rb;
    logic [STAT_W-1:0] obs_cnt;

    task automatic step(input bit f, input bit s);
        fast_tick = f;
        slow_tick = s;
        @(negedge clk_sys);
        obs_ce  = bus.cpu_ce;
        obs_sc  = slow_cycle;
        obs_rb  = refresh_busy;
        obs_cnt = slow_count;
        @(posedge clk_sys);
        #1;
        fast_tick = 1'b0;
        slow_tick = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        step(0, 0);
        reset_n = 1'b1;
    endtask

    task automatic set_bus(input logic [7:0] cya, input logic [3:0] mot, input logic [7:0] sh,
                           input logic [7:0] bk, input logic [15:0] a, input logic we);
        cyareg     = cya;
        motor_on   = mot;
        shadow     = sh;
        bus.bank   = bk;
        bus.addr   = a;
        bus.valid  = 1'b1;
        bus.cpu_we = we;
    endtask

    initial begin
        int ce_n;
        int rb_rise;
        bit prev_rb;

        set_bus(8'h80, 4'h0, 8'hFF, 8'h00, 16'h1000, 1'b1);
        #1 reset_n = 1'b0;
        @(posedge clk_sys);
        #1;
        step(0, 0);
        chk("reset_ce", 32'(obs_ce), 0);
        chk("reset_slow_cycle", 32'(obs_sc), 0);
        chk("reset_refresh_busy", 32'(obs_rb), 0);
        chk("reset_slow_count", 32'(obs_cnt), 0);
        reset_n = 1'b1;

        // Refresh stealing: 20 fast ticks, plus one more to expose the second steal.
        ce_n = 0; rb_rise = 0; prev_rb = 1'b0;
        for (int i = 0; i < 21; i++) begin
            step(1, 0);
            if (i < 20) ce_n += int'(obs_ce);
            if (obs_rb && !prev_rb) rb_rise++;
            prev_rb = obs_rb;
            step(0, 0);
            if (obs_rb && !prev_rb) rb_rise++;
            prev_rb = obs_rb;
        end
        chk("refresh_ce_count", 32'(ce_n), REF_ON ? 18 : 20);
        chk("refresh_pulses", 32'(rb_rise), REF_ON ? 2 : 0);

        // All-slow mode: each cycle starts on fast_tick and ends on the second slow_tick.
        do_reset();
        set_bus(8'h00, 4'h0, 8'hFF, 8'h00, 16'h1000, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1, 0); chk("slow_start_ce", 32'(obs_ce), 0);
            step(0, 0); chk("slow_sync_flag", 32'(obs_sc), 1);
            step(0, 1); chk("slow_first_tick_ce", 32'(obs_ce), 0);
            step(0, 0);
            step(0, 1); chk("slow_end_ce", 32'(obs_ce), 1);
        end
        step(0, 0);
        chk("slow_count_3", 32'(obs_cnt), 3);
        chk("slow_flag_clear", 32'(obs_sc), 0);

        // I/O access with coincident ticks skips SYNC.
        do_reset();
        set_bus(8'h80, 4'h0, 8'h00, 8'h00, 16'hC030, 1'b1);
        step(1, 1); chk("c030_start_ce", 32'(obs_ce), 0);
        step(0, 0); chk("c030_in_slow", 32'(obs_sc), 1);
        step(1, 0); chk("c030_fast_ignored", 32'(obs_ce), 0);
        step(0, 1); chk("c030_end_ce", 32'(obs_ce), 1);
        step(0, 0); chk("c030_count", 32'(obs_cnt), 1);

        // Motor detect forces slow; afterwards the refresh count restarts from 0.
        do_reset();
        set_bus(8'h84, 4'h0, 8'hFF, 8'h00, 16'h1000, 1'b1);
        for (int i = 0; i < 3; i++) begin step(1, 0); step(0, 0); end
        motor_on = 4'b0100;
        step(1, 0); chk("motor_slow_start", 32'(obs_ce), 0);
        step(0, 1);
        step(0, 1); chk("motor_slow_end", 32'(obs_ce), 1);
        motor_on = 4'b0000;
        ce_n = 0;
        for (int i = 0; i < 10; i++) begin
            step(1, 0);
            if (i == 0) chk("motor_off_fast", 32'(obs_ce), 1);
            ce_n += int'(obs_ce);
            step(0, 0);
        end
        chk("refresh_restart", 32'(ce_n), REF_ON ? 9 : 10);

        // Shadowed text-page write.
        do_reset();
        set_bus(8'h80, 4'h0, 8'hFE, 8'h00, 16'h0500, 1'b0);
        step(1, 0); chk("shwr_slow_ce", 32'(obs_ce), 0);
        step(0, 0); chk("shwr_slow_flag", 32'(obs_sc), 1);
        step(0, 1);
        step(0, 1); chk("shwr_slow_end", 32'(obs_ce), 1);
        shadow = 8'hFF;
        step(1, 0); chk("shwr_inhibit_fast", 32'(obs_ce), 1);
        step(0, 0);
        shadow = 8'hFE; bus.cpu_we = 1'b1;
        step(1, 0); chk("shrd_fast", 32'(obs_ce), 1);
        step(0, 0);

        // Reset while in SLOW abandons the cycle.
        do_reset();
        set_bus(8'h00, 4'h0, 8'hFF, 8'h00, 16'h1000, 1'b1);
        step(1, 1);
        step(0, 1);
        step(1, 1);
        step(0, 0); chk("pre_reset_in_slow", 32'(obs_sc), 1);
        reset_n = 1'b0;
        #1;
        chk("async_reset_flag", 32'(slow_cycle), 0);
        chk("async_reset_count", 32'(slow_count), 0);
        chk("async_reset_ce", 32'(bus.cpu_ce), 0);
        step(0, 1);
        reset_n = 1'b1;
        step(0, 1); chk("post_reset_no_ce", 32'(obs_ce), 0);
        cyareg = 8'h80;
        step(1, 0); chk("post_reset_fast", 32'(obs_ce), 1);

        // slow_count wraps at 2^STAT_W.
        do_reset();
        set_bus(8'h00, 4'h0, 8'hFF, 8'h00, 16'h1000, 1'b1);
        for (int i = 0; i < 17; i++) begin step(1, 1); step(0, 1); end
        step(0, 0); chk("count_wrap", 32'(obs_cnt), 1);

        // Randomized traffic; the model process checks every clock.
        begin
            int fgap = 0;
            int sgap = 3;
            bit prev_s = 1'b0;
            bit f, s;
            for (int n = 0; n < 4000; n++) begin
                s = (sgap == 0);
                if (s) sgap = $urandom_range(11, 6); else sgap--;
                f = 1'b0;
                if (fgap > 0) fgap--;
                else if (!prev_s) begin f = 1'b1; fgap = $urandom_range(3, 1); end
                prev_s = s;
                if ($urandom_range(4, 0) == 0) begin
                    cyareg   = {($urandom_range(7, 0) != 0), 3'($urandom),
                                ($urandom_range(3, 0) == 0) ? 4'($urandom) : 4'h0};
                    motor_on = 4'($urandom);
                    shadow   = $urandom_range(1, 0) ? 8'hFF : 8'($urandom);
                    case ($urandom_range(5, 0))
                        0: bus.bank = 8'h00;
                        1: bus.bank = 8'h01;
                        2: bus.bank = 8'hE0;
                        3: bus.bank = 8'hE1;
                        4: bus.bank = 8'h02;
                        default: bus.bank = 8'($urandom);
                    endcase
                    case ($urandom_range(5, 0))
                        0: bus.addr = 16'h0400 + 16'($urandom_range(16'h03FF, 0));
                        1: bus.addr = 16'h2000 + 16'($urandom_range(16'h1FFF, 0));
                        2: bus.addr = 16'h4000 + 16'($urandom_range(16'h1FFF, 0));
                        3: bus.addr = 16'hC000 + 16'($urandom_range(255, 0));
                        4: bus.addr = 16'h6000 + 16'($urandom_range(16'h3FFF, 0));
                        default: bus.addr = 16'($urandom);
                    endcase
                    bus.valid  = 1'($urandom);
                    bus.cpu_we = 1'($urandom);
                end
                reset_n = ($urandom_range(1499, 0) != 0);
                step(f, s);
                reset_n = 1'b1;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/iigs_speed_ctl.md
# iigs_speed_ctl

CPU clock-enable scheduler for the IIgs core. Sits between the clock-tick generators and the P65C816 `CE` input. Each bus cycle runs at fast speed or is stretched onto the 1 MHz Mega II timeline. The choice depends on CYAREG, the shadow register, the current bank/address and the disk motor state. With refresh compiled in, the block also steals periodic fast cycles for DRAM refresh.

## Interface
Parameters:
- REFRESH_PERIOD, 9: number of fast CPU cycles between stolen refresh cycles (legal 2..255).
- STAT_W, 16: width of the slow-cycle statistics counter.

Ports (clock and reset first):
- clk_sys  input  1  system clock; all logic is on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- fast_tick  input  1  one-clk_sys pulse at the fast CPU rate.
- slow_tick  input  1  one-clk_sys pulse at the 1 MHz Mega II rate.
- cyareg  input  8  CYAREG:
  - bit 7: fast mode.
  - bits 3:0: motor-detect enables for slots 4..7.
- motor_on  input  4  disk motor active, slots 4..7.
- shadow  input  8  shadow register ($C035).
- bank  input  8  bank byte of the current CPU address.
- addr  input  16  address of the current CPU cycle.
- valid  input  1  VPA|VDA for the current cycle.
- cpu_we  input  1  CPU WE; 0 = write, which is the codebase polarity.
- cpu_ce  output  1  one-clk_sys pulse that advances the CPU.
- slow_cycle  output  1  high while a slow cycle is in progress.
- refresh_busy  output  1  high while a refresh steal is in progress.
- slow_count  output  STAT_W  number of completed slow cycles; wraps.

## Operation
- A cycle is classified **slow** if any of the following holds:
  - cyareg[7]==0.
  - |(cyareg[3:0] & motor_on) is 1.
  - valid==1 and bank is E0 or E1.
  - valid==1, bank is 00/01/E0/E1, addr[15:8]==C0 and shadow[6]==0.
  - Shadowed write (valid==1, cpu_we==0), bank 00 or 01, in any of these windows:
    - addr 0400–07FF with shadow[0]==0.
    - addr 2000–3FFF with shadow[1]==0.
    - addr 4000–5FFF with shadow[2]==0.
    - bank 01, addr 2000–9FFF, with shadow[3]==0.
- Otherwise the cycle is **fast**.
- Classification is sampled on the tick that would start the cycle. Inputs are stable between cpu_ce pulses.
- States and transitions:
  - **FAST**, on fast_tick:
    - Fast cycle, no refresh due: cpu_ce=1.
    - Refresh due: go to REFRESH, no cpu_ce.
    - Slow cycle: go to SYNC. If slow_tick is also present in the same clock, go directly to SLOW.
  - **SYNC**: on slow_tick, go to SLOW. fast_tick is ignored.
  - **SLOW**: on slow_tick, cpu_ce=1, slow_count+=1, return to FAST.
  - **REFRESH**: the next fast_tick is swallowed (no cpu_ce); return to FAST. The refresh counter clears.
- Refresh counter:
  - Increments on each fast cpu_ce.
  - Refresh is due when the counter reaches REFRESH_PERIOD.
  - Clears on any slow cycle completion; the Mega II refreshes itself.
- A slow cycle, once entered, always completes, even if cyareg, shadow or motor_on change mid-cycle.
- slow_cycle = state is SYNC or SLOW. refresh_busy = state is REFRESH.

## Timing
- Reset: state FAST; cpu_ce=0, slow_cycle=0, refresh_busy=0; slow_count=0; refresh counter=0. Asserting reset mid-cycle abandons the cycle with no cpu_ce.
- Fast cycle: cpu_ce is combinational with the fast_tick clock, i.e. zero-cycle latency from the tick.
- Slow cycle: 1 to 2 slow_tick periods. cpu_ce coincides with the terminating slow_tick. slow_cycle rises the clock after the starting fast_tick.
- cpu_ce is never high in two consecutive clk_sys cycles.
- fast_tick arriving in SYNC, SLOW or REFRESH (except the one swallowed by REFRESH) is ignored.
- slow_count wraps from 2^STAT_W−1 to 0.

## Configuration
- IIGS_SPEED_REFRESH_EN defined: the refresh counter and REFRESH state are built in.
- Undefined:
  - The refresh logic is removed.
  - refresh_busy is tied to 0.
  - Every fast cycle issues cpu_ce on its fast_tick.

## Test plan
- Refresh on: cyareg=80, shadow=FF, bank=00, addr=1000, 20 fast_ticks -> 18 cpu_ce; refresh_busy pulses after the 9th and 18th cpu_ce.
- cyareg=00, addr=1000 -> every cpu_ce aligned to a slow_tick; slow_count increments per cycle; slow_cycle high between the start fast_tick and the end slow_tick.
- cyareg=80, shadow=00, bank=00, addr=C030, valid=1, fast_tick and slow_tick in the same clock -> no SYNC; cpu_ce on the next slow_tick.
- cyareg=84, motor_on=0100 -> slow; motor_on=0000 -> fast again on the next cycle; refresh counter restarted from 0.
- Write to 00:0500 with shadow[0]=0 -> slow; with shadow[0]=1 -> fast; read of 00:0500 with shadow[0]=0 -> fast.
- reset_n pulsed low while in SLOW -> outputs 0 immediately; no cpu_ce until the next fast_tick; slow_count=0.
